// File: rtl/vend_fsm_param.sv
// Coin vending controller: accumulates nickel/dime/quarter credit
// against PRICE, vends, then pays change or refunds one nickel per cycle.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_nickel     5-cent coin pulse
//   i_dime       10-cent coin pulse
//   i_quarter    25-cent coin pulse
//   i_cancel     refund request pulse
//   o_soda       vend pulse
//   o_change     nickels owed, only in the vend/refund-start cycle
//   o_nickel_out one pulse per returned nickel
//   o_reject     an inserted coin was returned
//   o_busy       paying change or refund
//   o_credit     accumulated credit in cents
module vend_fsm_param #(
    parameter int PRICE    = 20,
    parameter int CREDIT_W = 8,
    parameter int CHG_W    = 6
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_nickel,
    input  logic                i_dime,
    input  logic                i_quarter,
    input  logic                i_cancel,
    output logic                o_soda,
    output logic [CHG_W-1:0]    o_change,
    output logic                o_nickel_out,
    output logic                o_reject,
    output logic                o_busy,
    output logic [CREDIT_W-1:0] o_credit
);

    if ((PRICE % 5) != 0 || PRICE < 5 || PRICE > 200) begin : g_bad_price
        $error("vend_fsm_param: PRICE must be a multiple of 5 in 5..200");
    end

    if ((PRICE + 20) >= (1 << CREDIT_W)) begin : g_bad_credit_w
        $error("vend_fsm_param: CREDIT_W cannot hold PRICE+20");
    end

    if (((PRICE + 20) / 5) >= (1 << CHG_W)) begin : g_bad_chg_w
        $error("vend_fsm_param: CHG_W cannot hold (PRICE+20)/5");
    end

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_PAY     = 1'b1;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] FIVE    = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] TEN     = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] TWENTY5 = CREDIT_W'(25);
    localparam logic [CHG_W-1:0]    ONE_CHG = CHG_W'(1);

    logic [0:0]          state;
    logic [0:0]          state_nxt;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [CHG_W-1:0]    remaining;
    logic [CHG_W-1:0]    remaining_nxt;

    logic                soda_nxt;
    logic [CHG_W-1:0]    change_nxt;
    logic                nickel_out_nxt;
    logic                reject_nxt;
    logic                busy_nxt;

    logic                any_coin;
    logic                extra_coin;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] sum;
    logic [CREDIT_W-1:0] over;
    logic                vend;
    logic [CHG_W-1:0]    vend_change;
    logic [CHG_W-1:0]    refund_change;

    // Priority nickel > dime > quarter; only one coin is taken per cycle.
    always_comb begin
        coin_val = '0;
        if (i_nickel) begin
            coin_val = FIVE;
        end else if (i_dime) begin
            coin_val = TEN;
        end else if (i_quarter) begin
            coin_val = TWENTY5;
        end
    end

    assign any_coin   = i_nickel | i_dime | i_quarter;
    // Any coin beyond the accepted one is handed back.
    assign extra_coin = (i_nickel & (i_dime | i_quarter)) |
                        (i_dime & i_quarter);

    // Credit stays below PRICE in COLLECT, so sum cannot overflow.
    assign sum  = credit + coin_val;
    assign vend = any_coin && (sum >= PRICE_C);
    assign over = sum - PRICE_C;

    // Credit is always a whole number of nickels.
    assign vend_change   = CHG_W'(over / FIVE);
    assign refund_change = CHG_W'(sum / FIVE);

    always_comb begin
        state_nxt      = state;
        credit_nxt     = credit;
        remaining_nxt  = remaining;
        soda_nxt       = 1'b0;
        change_nxt     = '0;
        nickel_out_nxt = 1'b0;
        reject_nxt     = 1'b0;
        busy_nxt       = 1'b0;

        unique case (state)
            ST_COLLECT: begin
                reject_nxt = extra_coin;
                if (vend) begin
                    // A vend takes precedence over a same-cycle cancel.
                    soda_nxt   = 1'b1;
                    change_nxt = vend_change;
                    credit_nxt = '0;
                    if (vend_change != '0) begin
                        state_nxt     = ST_PAY;
                        remaining_nxt = vend_change;
                    end
                end else if (i_cancel && (sum != '0)) begin
                    // The coin arriving with the cancel is refunded too.
                    change_nxt    = refund_change;
                    credit_nxt    = '0;
                    state_nxt     = ST_PAY;
                    remaining_nxt = refund_change;
                end else begin
                    credit_nxt = sum;
                end
            end

            ST_PAY: begin
                reject_nxt     = any_coin;
                busy_nxt       = 1'b1;
                nickel_out_nxt = 1'b1;
                remaining_nxt  = remaining - ONE_CHG;
                if (remaining <= ONE_CHG) begin
                    state_nxt     = ST_COLLECT;
                    remaining_nxt = '0;
                end
            end

            default: begin
                state_nxt     = ST_COLLECT;
                credit_nxt    = '0;
                remaining_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_COLLECT;
            credit       <= '0;
            remaining    <= '0;
            o_soda       <= 1'b0;
            o_change     <= '0;
            o_nickel_out <= 1'b0;
            o_reject     <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            remaining    <= remaining_nxt;
            o_soda       <= soda_nxt;
            o_change     <= change_nxt;
            o_nickel_out <= nickel_out_nxt;
            o_reject     <= reject_nxt;
            o_busy       <= busy_nxt;
        end
    end

    assign o_credit = credit;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Bench for vend_fsm_param: directed scenarios with literal checks plus
// random coin traffic compared every cycle against a cents/nickels model.
module tb_vend_fsm_param;

    localparam int PRICE    = 20;
    localparam int CREDIT_W = 8;
    localparam int CHG_W    = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic                nickel;
    logic                dime;
    logic                quarter;
    logic                cancel;
    logic                soda;
    logic [CHG_W-1:0]    change;
    logic                nickel_out;
    logic                reject;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: credit in cents, nickels still owed to the customer.
    int m_credit = 0;
    int m_owed   = 0;
    int e_soda;
    int e_change;
    int e_nick;
    int e_rej;
    int e_busy;
    int e_credit;
    bit model_valid = 1'b0;

    vend_fsm_param #(
        .PRICE   (PRICE),
        .CREDIT_W(CREDIT_W),
        .CHG_W   (CHG_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_nickel    (nickel),
        .i_dime      (dime),
        .i_quarter   (quarter),
        .i_cancel    (cancel),
        .o_soda      (soda),
        .o_change    (change),
        .o_nickel_out(nickel_out),
        .o_reject    (reject),
        .o_busy      (busy),
        .o_credit    (credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        int v;
        int total;
        int ncoins;
        e_soda   = 0;
        e_change = 0;
        e_nick   = 0;
        e_rej    = 0;
        e_busy   = 0;
        if (rst) begin
            m_credit = 0;
            m_owed   = 0;
        end else if (m_owed > 0) begin
            e_nick = 1;
            e_busy = 1;
            m_owed = m_owed - 1;
            e_rej  = (nickel || dime || quarter) ? 1 : 0;
        end else begin
            ncoins = int'(nickel) + int'(dime) + int'(quarter);
            e_rej  = (ncoins > 1) ? 1 : 0;
            v = nickel ? 5 : dime ? 10 : quarter ? 25 : 0;
            total = m_credit + v;
            if (v > 0 && total >= PRICE) begin
                e_soda   = 1;
                e_change = (total - PRICE) / 5;
                m_owed   = e_change;
                m_credit = 0;
            end else if (cancel && total > 0) begin
                e_change = total / 5;
                m_owed   = e_change;
                m_credit = 0;
            end else begin
                m_credit = total;
            end
        end
        e_credit    = m_credit;
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("soda",       32'(soda),       32'(e_soda));
            chk("change",     32'(change),     32'(e_change));
            chk("nickel_out", 32'(nickel_out), 32'(e_nick));
            chk("reject",     32'(reject),     32'(e_rej));
            chk("busy",       32'(busy),       32'(e_busy));
            chk("credit",     32'(credit),     32'(e_credit));
        end
    end

    task automatic drive(input logic n, input logic d, input logic q,
                         input logic c, input logic r);
        nickel  = n;
        dime    = d;
        quarter = q;
        cancel  = c;
        rst     = r;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_soda",   32'(soda),   32'd0);
        chk("rst_busy",   32'(busy),   32'd0);

        // Four nickels: credit 5,10,15 then exact vend.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("n1_credit", 32'(credit), 32'd5);
        idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("n2_credit", 32'(credit), 32'd10);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("n3_credit", 32'(credit), 32'd15);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("n4_soda",   32'(soda),   32'd1);
        chk("n4_change", 32'(change), 32'd0);
        chk("n4_credit", 32'(credit), 32'd0);
        idle();
        chk("n4_busy",   32'(busy),   32'd0);

        // Quarter from zero: one nickel back.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("q_soda",   32'(soda),   32'd1);
        chk("q_change", 32'(change), 32'd1);
        idle();
        chk("q_nick",   32'(nickel_out), 32'd1);
        chk("q_busy",   32'(busy),       32'd1);
        idle();
        chk("q_nick_end", 32'(nickel_out), 32'd0);
        chk("q_busy_end", 32'(busy),       32'd0);

        // 15 + quarter: four nickels, a dime rejected mid-payout.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("nd_credit", 32'(credit), 32'd15);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ndq_soda",   32'(soda),   32'd1);
        chk("ndq_change", 32'(change), 32'd4);
        idle();
        chk("ndq_p1", 32'(nickel_out), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ndq_p2",     32'(nickel_out), 32'd1);
        chk("pay_reject", 32'(reject),     32'd1);
        chk("pay_credit", 32'(credit),     32'd0);
        idle();
        chk("ndq_p3", 32'(nickel_out), 32'd1);
        idle();
        chk("ndq_p4",   32'(nickel_out), 32'd1);
        chk("ndq_busy", 32'(busy),       32'd1);
        idle();
        chk("ndq_done", 32'(busy), 32'd0);

        // Refund of 15 cents.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("cx_soda",   32'(soda),   32'd0);
        chk("cx_change", 32'(change), 32'd3);
        chk("cx_credit", 32'(credit), 32'd0);
        idle();
        idle();
        idle();
        chk("cx_p3", 32'(nickel_out), 32'd1);
        idle();
        chk("cx_done", 32'(busy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("cx0_change", 32'(change), 32'd0);
        chk("cx0_busy",   32'(busy),   32'd0);

        // Two coins at once: nickel kept, quarter rejected.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("nq_credit", 32'(credit), 32'd5);
        chk("nq_reject", 32'(reject), 32'd1);

        // Reset in the second cycle of a four-nickel payout.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rp_change", 32'(change), 32'd4);
        idle();
        chk("rp_p1", 32'(nickel_out), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rp_nick", 32'(nickel_out), 32'd0);
        chk("rp_busy", 32'(busy),       32'd0);
        idle();
        idle();
        chk("rp_after", 32'(nickel_out), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rp_q_soda",   32'(soda),   32'd1);
        chk("rp_q_change", 32'(change), 32'd1);
        idle();
        idle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            drive(logic'($urandom_range(0, 4) == 0),
                  logic'($urandom_range(0, 4) == 0),
                  logic'($urandom_range(0, 6) == 0),
                  logic'($urandom_range(0, 9) == 0),
                  logic'($urandom_range(0, 99) == 0));
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
